// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: signal bundle between the ID-stage front end and ctrl_pipe.
//   master: drives opcode/id_valid/stall/flush, observes the stage controls.
//   slave : ctrl_pipe side; receives the ID-stage inputs, drives id_jump,
//           per-stage valid/control outputs and the illegal-opcode status.
interface ctrl_pipe_if #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 2,
    parameter int unsigned CNT_W    = 8
);
    logic [OPCODE_W-1:0] opcode;
    logic                id_valid;
    logic                stall;
    logic                flush;
    logic                id_jump;
    logic                ex_valid;
    logic                mem_valid;
    logic                wb_valid;
    logic                ex_RegDst;
    logic                ex_ALUsrc;
    logic [ALUOP_W-1:0]  ex_ALUop;
    logic                mem_Branch;
    logic                mem_BranchNe;
    logic                mem_MemRead;
    logic                mem_MemWrite;
    logic                wb_RegWrite;
    logic                wb_MemtoReg;
    logic                illegal_op;
    logic [CNT_W-1:0]    illegal_count;

    modport master (
        output opcode, id_valid, stall, flush,
        input  id_jump, ex_valid, mem_valid, wb_valid,
        input  ex_RegDst, ex_ALUsrc, ex_ALUop,
        input  mem_Branch, mem_BranchNe, mem_MemRead, mem_MemWrite,
        input  wb_RegWrite, wb_MemtoReg,
        input  illegal_op, illegal_count
    );

    modport slave (
        input  opcode, id_valid, stall, flush,
        output id_jump, ex_valid, mem_valid, wb_valid,
        output ex_RegDst, ex_ALUsrc, ex_ALUop,
        output mem_Branch, mem_BranchNe, mem_MemRead, mem_MemWrite,
        output wb_RegWrite, wb_MemtoReg,
        output illegal_op, illegal_count
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined main control unit for the 5-stage MIPS core.
// Decodes the ID-stage opcode into a control bundle and carries it through
// the ID/EX, EX/MEM and MEM/WB registers, inserting bubbles on stall/flush
// and counting illegal opcodes (sticky flag + saturating counter).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - ctrl_pipe_if.slave: opcode/id_valid/stall/flush in; id_jump,
//          ex_*/mem_*/wb_* stage controls, illegal_op, illegal_count out
module ctrl_pipe #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 2,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned EXT_OPS  = 1
) (
    input logic        clk,
    input logic        rst,
    ctrl_pipe_if.slave bus
);

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

    localparam bit EXT = (EXT_OPS != 0);

    // Each register only keeps the fields still needed downstream.
    typedef struct packed {
        logic               valid;
        logic               reg_dst;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               branch;
        logic               branch_ne;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               memto_reg;
    } ex_ctl_t;

    typedef struct packed {
        logic valid;
        logic branch;
        logic branch_ne;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic memto_reg;
    } mem_ctl_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic memto_reg;
    } wb_ctl_t;

    ex_ctl_t            dec;
    ex_ctl_t            ex_d, ex_q;
    mem_ctl_t           mem_d, mem_q;
    wb_ctl_t            wb_d, wb_q;
    logic               illegal_op_d, illegal_op_q;
    logic [CNT_W-1:0]   illegal_count_d, illegal_count_q;
    logic               count_en;

    // Decoder: illegal opcodes fall through to an all-zero, invalid bundle,
    // which is identical to a bubble.
    always_comb begin
        dec = '0;
        case (bus.opcode)
            OP_R: begin
                dec.valid     = 1'b1;
                dec.reg_dst   = 1'b1;
                dec.alu_op    = ALU_FUNCT;
                dec.reg_write = 1'b1;
            end
            OP_LW: begin
                dec.valid     = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.memto_reg = 1'b1;
            end
            OP_SW: begin
                dec.valid     = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.mem_write = 1'b1;
            end
            OP_BNE: begin
                dec.valid     = 1'b1;
                dec.alu_op    = ALU_SUB;
                dec.branch_ne = 1'b1;
            end
            OP_BEQ: begin
                if (EXT) begin
                    dec.valid  = 1'b1;
                    dec.alu_op = ALU_SUB;
                    dec.branch = 1'b1;
                end
            end
            OP_ADDI: begin
                if (EXT) begin
                    dec.valid     = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.alu_op    = ALU_ADD;
                    dec.reg_write = 1'b1;
                end
            end
            OP_J: begin
                // Jump resolves in ID; it travels down as a valid no-op.
                dec.valid = EXT;
            end
            default: ;
        endcase
    end

    // Pipeline advance. Priority: flush > stall > normal (rst handled in the
    // register). MEM/WB always takes EX/MEM so older instructions drain.
    always_comb begin
        wb_d.valid     = mem_q.valid;
        wb_d.reg_write = mem_q.reg_write;
        wb_d.memto_reg = mem_q.memto_reg;

        mem_d.valid     = ex_q.valid;
        mem_d.branch    = ex_q.branch;
        mem_d.branch_ne = ex_q.branch_ne;
        mem_d.mem_read  = ex_q.mem_read;
        mem_d.mem_write = ex_q.mem_write;
        mem_d.reg_write = ex_q.reg_write;
        mem_d.memto_reg = ex_q.memto_reg;

        ex_d = bus.id_valid ? dec : '0;

        if (bus.flush) begin
            ex_d  = '0;
            mem_d = '0;
        end else if (bus.stall) begin
            ex_d = '0;
        end
    end

    // A stalled instruction is re-presented later, so only count it when
    // it actually enters the pipeline.
    always_comb begin
        count_en        = bus.id_valid && !dec.valid && !bus.stall && !bus.flush;
        illegal_op_d    = illegal_op_q | count_en;
        illegal_count_d = illegal_count_q;
        if (count_en && (illegal_count_q != '1)) begin
            illegal_count_d = illegal_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q            <= '0;
            mem_q           <= '0;
            wb_q            <= '0;
            illegal_op_q    <= 1'b0;
            illegal_count_q <= '0;
        end else begin
            ex_q            <= ex_d;
            mem_q           <= mem_d;
            wb_q            <= wb_d;
            illegal_op_q    <= illegal_op_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign bus.id_jump       = bus.id_valid && EXT && (bus.opcode == OP_J);
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_RegDst     = ex_q.reg_dst;
    assign bus.ex_ALUsrc     = ex_q.alu_src;
    assign bus.ex_ALUop      = ex_q.alu_op;
    assign bus.mem_valid     = mem_q.valid;
    assign bus.mem_Branch    = mem_q.branch;
    assign bus.mem_BranchNe  = mem_q.branch_ne;
    assign bus.mem_MemRead   = mem_q.mem_read;
    assign bus.mem_MemWrite  = mem_q.mem_write;
    assign bus.wb_valid      = wb_q.valid;
    assign bus.wb_RegWrite   = wb_q.reg_write;
    assign bus.wb_MemtoReg   = wb_q.memto_reg;
    assign bus.illegal_op    = illegal_op_q;
    assign bus.illegal_count = illegal_count_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: scoreboard bench for ctrl_pipe. Two instances share one
// stimulus stream: dut0 with the extended opcodes and an 8-bit counter,
// dut1 with base opcodes only and a 2-bit counter (saturation visible).
module tb_ctrl_pipe;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(8)) bus0 ();
    ctrl_pipe_if #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(2)) bus1 ();

    ctrl_pipe #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(8), .EXT_OPS(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    ctrl_pipe #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(2), .EXT_OPS(0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct packed {
        logic       valid;
        logic       regdst;
        logic       alusrc;
        logic [1:0] aluop;
        logic       branch;
        logic       branchne;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
    } ctl_t;

    typedef struct {
        logic jump;
        ctl_t ex;
        ctl_t mem;
        ctl_t wb;
        logic ill;
        int   cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    ctl_t m_ex [2];
    ctl_t m_mem[2];
    ctl_t m_wb [2];
    logic m_ill[2];
    int   m_cnt[2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference decode table straight from the instruction list.
    function automatic ctl_t decode(input logic [5:0] op, input bit ext);
        ctl_t c;
        c = '0;
        case (op)
            R:    begin c.valid = 1; c.regdst = 1; c.aluop = 2'b10; c.regwrite = 1; end
            LW:   begin c.valid = 1; c.alusrc = 1; c.memread = 1; c.regwrite = 1; c.memtoreg = 1; end
            SW:   begin c.valid = 1; c.alusrc = 1; c.memwrite = 1; end
            BNE:  begin c.valid = 1; c.aluop = 2'b01; c.branchne = 1; end
            BEQ:  if (ext) begin c.valid = 1; c.aluop = 2'b01; c.branch = 1; end
            ADDI: if (ext) begin c.valid = 1; c.alusrc = 1; c.regwrite = 1; end
            J:    if (ext) c.valid = 1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle=%0d actual=%h expected=%h",
                     name, d, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model across the
    // coming edge and queue what each DUT must show after it.
    task automatic step(input logic r, input logic v, input logic st,
                        input logic fl, input logic [5:0] op);
        exp_t e;
        ctl_t dc;
        bit   ext;
        int   cmax;
        @(negedge clk);
        rst = r;
        bus0.opcode = op; bus0.id_valid = v; bus0.stall = st; bus0.flush = fl;
        bus1.opcode = op; bus1.id_valid = v; bus1.stall = st; bus1.flush = fl;
        for (int d = 0; d < 2; d++) begin
            ext  = (d == 0);
            cmax = (d == 0) ? 255 : 3;
            dc   = decode(op, ext);
            e.jump = v && ext && (op == J);
            if (r) begin
                m_ex[d] = '0; m_mem[d] = '0; m_wb[d] = '0;
                m_ill[d] = 1'b0; m_cnt[d] = 0;
            end else begin
                m_wb[d]  = m_mem[d];
                m_mem[d] = fl ? '0 : m_ex[d];
                m_ex[d]  = (fl || st || !v) ? '0 : dc;
                if (v && !dc.valid && !st && !fl) begin
                    m_ill[d] = 1'b1;
                    if (m_cnt[d] < cmax) m_cnt[d]++;
                end
            end
            e.ex = m_ex[d]; e.mem = m_mem[d]; e.wb = m_wb[d];
            e.ill = m_ill[d]; e.cnt = m_cnt[d];
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // Monitor: every stage output is presented each cycle; compare after
    // each edge whenever an expectation is pending.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                chk("jump", 0, 32'(bus0.id_jump), 32'(e0.jump));
                chk("ex", 0, 32'({bus0.ex_valid, bus0.ex_RegDst, bus0.ex_ALUsrc, bus0.ex_ALUop}),
                    32'({e0.ex.valid, e0.ex.regdst, e0.ex.alusrc, e0.ex.aluop}));
                chk("mem", 0, 32'({bus0.mem_valid, bus0.mem_Branch, bus0.mem_BranchNe,
                                   bus0.mem_MemRead, bus0.mem_MemWrite}),
                    32'({e0.mem.valid, e0.mem.branch, e0.mem.branchne,
                         e0.mem.memread, e0.mem.memwrite}));
                chk("wb", 0, 32'({bus0.wb_valid, bus0.wb_RegWrite, bus0.wb_MemtoReg}),
                    32'({e0.wb.valid, e0.wb.regwrite, e0.wb.memtoreg}));
                chk("illegal_op", 0, 32'(bus0.illegal_op), 32'(e0.ill));
                chk("illegal_count", 0, 32'(bus0.illegal_count), 32'(e0.cnt));
            end
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("jump", 1, 32'(bus1.id_jump), 32'(e1.jump));
                chk("ex", 1, 32'({bus1.ex_valid, bus1.ex_RegDst, bus1.ex_ALUsrc, bus1.ex_ALUop}),
                    32'({e1.ex.valid, e1.ex.regdst, e1.ex.alusrc, e1.ex.aluop}));
                chk("mem", 1, 32'({bus1.mem_valid, bus1.mem_Branch, bus1.mem_BranchNe,
                                   bus1.mem_MemRead, bus1.mem_MemWrite}),
                    32'({e1.mem.valid, e1.mem.branch, e1.mem.branchne,
                         e1.mem.memread, e1.mem.memwrite}));
                chk("wb", 1, 32'({bus1.wb_valid, bus1.wb_RegWrite, bus1.wb_MemtoReg}),
                    32'({e1.wb.valid, e1.wb.regwrite, e1.wb.memtoreg}));
                chk("illegal_op", 1, 32'(bus1.illegal_op), 32'(e1.ill));
                chk("illegal_count", 1, 32'(bus1.illegal_count), 32'(e1.cnt));
            end
        end
    end

    initial begin
        logic [5:0] ops[7];
        logic [5:0] op;
        int         sel;
        ops[0] = R; ops[1] = LW; ops[2] = SW; ops[3] = BNE;
        ops[4] = BEQ; ops[5] = ADDI; ops[6] = J;

        rst = 1'b1;
        bus0.opcode = '0; bus0.id_valid = 1'b0; bus0.stall = 1'b0; bus0.flush = 1'b0;
        bus1.opcode = '0; bus1.id_valid = 1'b0; bus1.stall = 1'b0; bus1.flush = 1'b0;

        // Reset, then a lone lw through all stages.
        step(1, 0, 0, 0, R);
        step(1, 0, 0, 0, R);
        step(0, 1, 0, 0, LW);
        repeat (3) step(0, 0, 0, 0, R);

        // lw then R-type with a one-cycle load-use stall.
        step(0, 1, 0, 0, LW);
        step(0, 1, 1, 0, R);
        step(0, 1, 0, 0, R);
        repeat (3) step(0, 0, 0, 0, R);

        // beq, sw, addi with flush on the edge where beq sits in MEM.
        step(0, 1, 0, 0, BEQ);
        step(0, 1, 0, 0, SW);
        step(0, 1, 0, 1, ADDI);
        repeat (3) step(0, 0, 0, 0, R);

        // beq (illegal in dut1) once, then held under stall.
        step(0, 1, 0, 0, BEQ);
        repeat (3) step(0, 1, 1, 0, BEQ);
        step(0, 0, 0, 0, R);

        // Five unstalled illegal opcodes: dut1 saturates at 3.
        repeat (5) step(0, 1, 0, 0, BAD);

        // Simultaneous stall and flush.
        step(0, 1, 0, 0, SW);
        step(0, 1, 1, 1, R);

        // Jump, then reset mid-stream.
        step(0, 1, 0, 0, J);
        step(0, 0, 0, 0, R);
        step(0, 1, 0, 0, LW);
        step(1, 1, 0, 0, SW);
        step(0, 0, 0, 0, R);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 8);
            if (sel < 7) op = ops[sel];
            else         op = 6'($urandom);
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 10),
                 op);
        end
        repeat (3) step(0, 0, 0, 0, R);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q0.size() + q1.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 pending entries",
                     q0.size() + q1.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
